grid_mem_arbiter: RTL and testbench

- Shares the single-port 15x15 playfield memory (2-bit cells: 00 world, 01 food, 10 snake, 11 wall/invalid) between two clients.
- Clients: the VGA pixel fetch path (read-only, strict priority) and the game engine (read/write, req/ack handshake).
- Contains a clear sequencer that initialises every cell after reset or on command.
- Sits between the display controller, the game FSM, and the grid memory.

---
 rtl/grid_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_grid_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_mem_arbiter.sv
// Playfield memory arbiter: VGA fetch (strict priority) and game engine share one grid port,
// with a row-major clear sweep after reset or clear_start. Optional macro: GRID_BORDER_WALL_EN.
module grid_mem_arbiter #(
   parameter int GRID_W  = 15,
   parameter int GRID_H  = 15,
   parameter int COORD_W = 5,
   parameter int CELL_W  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               vga_req,
   input  logic [COORD_W-1:0] vga_x,
   input  logic [COORD_W-1:0] vga_y,
   output logic [CELL_W-1:0]  vga_data,
   input  logic               game_req,
   input  logic               game_we,
   input  logic [COORD_W-1:0] game_x,
   input  logic [COORD_W-1:0] game_y,
   input  logic [CELL_W-1:0]  game_wdata,
   output logic               game_ack,
   output logic [CELL_W-1:0]  game_rdata,
   input  logic               clear_start,
   output logic               clear_busy,
   output logic               mem_en,
   output logic               mem_we,
   output logic [COORD_W-1:0] mem_x,
   output logic [COORD_W-1:0] mem_y,
   output logic [CELL_W-1:0]  mem_wdata,
   input  logic [CELL_W-1:0]  mem_rdata
);

   typedef enum logic [0:0] {CLEAR, RUN} state_t;

   localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);
   localparam logic [COORD_W-1:0] MAX_X = COORD_W'(GRID_W);
   localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(GRID_H);

   state_t              state;
   state_t              state_nxt;
   logic [COORD_W-1:0]  sweep_x;
   logic [COORD_W-1:0]  sweep_y;
   logic                sweep_last;
   logic [CELL_W-1:0]   clear_value;
   logic                vga_in_range;
   logic                game_in_range;
   logic                vga_grant;
   logic                game_grant;
   logic                vga_pend;
   logic                vga_hit;
   logic                game_pend;
   logic                game_rd_hit;
   logic [CELL_W-1:0]   vga_data_q;

   assign sweep_last    = (sweep_x == MAX_X) && (sweep_y == MAX_Y);
   assign vga_in_range  = (vga_x >= ONE) && (vga_x <= MAX_X) && (vga_y >= ONE) && (vga_y <= MAX_Y);
   assign game_in_range = (game_x >= ONE) && (game_x <= MAX_X) && (game_y >= ONE) && (game_y <= MAX_Y);

`ifdef GRID_BORDER_WALL_EN
   assign clear_value = (sweep_x == ONE || sweep_x == MAX_X || sweep_y == ONE || sweep_y == MAX_Y)
                        ? '1 : '0;
`else
   assign clear_value = '0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) state <= CLEAR;
      else        state <= state_nxt;
   end

   // Grant decision and memory port drive; while reset is low every output is held at zero.
   always_comb begin
      state_nxt  = state;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_x      = '0;
      mem_y      = '0;
      mem_wdata  = '0;
      vga_grant  = 1'b0;
      game_grant = 1'b0;
      unique case (state)
         CLEAR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_x     = sweep_x;
            mem_y     = sweep_y;
            mem_wdata = clear_value;
            if (sweep_last) state_nxt = RUN;
         end
         RUN: begin
            if (clear_start) state_nxt = CLEAR;
            if (vga_req) begin
               vga_grant = 1'b1;
               if (vga_in_range) begin
                  mem_en = 1'b1;
                  mem_x  = vga_x;
                  mem_y  = vga_y;
               end
            end else if (game_req && !game_pend) begin
               game_grant = 1'b1;
               if (game_in_range) begin
                  mem_en    = 1'b1;
                  mem_we    = game_we;
                  mem_x     = game_x;
                  mem_y     = game_y;
                  mem_wdata = game_we ? game_wdata : '0;
               end
            end
         end
      endcase
      if (!reset) begin
         state_nxt  = CLEAR;
         mem_en     = 1'b0;
         mem_we     = 1'b0;
         mem_x      = '0;
         mem_y      = '0;
         mem_wdata  = '0;
         vga_grant  = 1'b0;
         game_grant = 1'b0;
      end
   end

   // Sweep counter rests at (1,1) outside CLEAR so a new sweep always starts from the corner.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sweep_x     <= ONE;
         sweep_y     <= ONE;
         vga_pend    <= 1'b0;
         vga_hit     <= 1'b0;
         game_pend   <= 1'b0;
         game_rd_hit <= 1'b0;
         vga_data_q  <= '0;
      end else begin
         if (state == CLEAR && !sweep_last) begin
            if (sweep_x == MAX_X) begin
               sweep_x <= ONE;
               sweep_y <= sweep_y + ONE;
            end else begin
               sweep_x <= sweep_x + ONE;
            end
         end else begin
            sweep_x <= ONE;
            sweep_y <= ONE;
         end
         vga_pend    <= vga_req;
         vga_hit     <= vga_grant && vga_in_range;
         if (vga_pend) vga_data_q <= vga_hit ? mem_rdata : '0;
         game_pend   <= game_grant;
         game_rd_hit <= game_grant && game_in_range && !game_we;
      end
   end

   assign vga_data   = reset ? vga_data_q : '0;
   assign game_ack   = reset && game_pend;
   assign game_rdata = (reset && game_pend && game_rd_hit) ? mem_rdata : '0;
   assign clear_busy = reset && (state == CLEAR);

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Scoreboard bench for grid_mem_arbiter: a behavioural grid model predicts VGA and game responses,
// a bench-side memory answers the DUT's port, and a monitor checks responses as they appear.
`timescale 1ns/1ps
module tb_grid_mem_arbiter;

   localparam int GW    = 15;
   localparam int GH    = 15;
   localparam int CW    = 5;
   localparam int DW    = 2;
   localparam int SWEEP = GW * GH;

   typedef struct {
      bit is_read;
      int rdata;
   } game_exp_t;

   logic          clk         = 1'b0;
   logic          reset       = 1'b0;
   logic          vga_req     = 1'b0;
   logic [CW-1:0] vga_x       = '0;
   logic [CW-1:0] vga_y       = '0;
   logic [DW-1:0] vga_data;
   logic          game_req    = 1'b0;
   logic          game_we     = 1'b0;
   logic [CW-1:0] game_x      = '0;
   logic [CW-1:0] game_y      = '0;
   logic [DW-1:0] game_wdata  = '0;
   logic          game_ack;
   logic [DW-1:0] game_rdata;
   logic          clear_start = 1'b0;
   logic          clear_busy;
   logic          mem_en;
   logic          mem_we;
   logic [CW-1:0] mem_x;
   logic [CW-1:0] mem_y;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata   = '0;

   logic [DW-1:0] bmem [0:31][0:31];
   int            shadow [0:GH+1][0:GW+1];
   int            vga_q [$];
   game_exp_t     game_q [$];
   int            vec_count  = 0;
   int            miscompares = 0;
   int            cyc        = 0;
   int            req_cyc    = 0;
   int            last_vga   = 0;
   logic [1:0]    vga_due    = 2'b00;
   int            lat;

   grid_mem_arbiter #(.GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .CELL_W(DW)) dut (
      .clk(clk), .reset(reset),
      .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y), .vga_data(vga_data),
      .game_req(game_req), .game_we(game_we), .game_x(game_x), .game_y(game_y),
      .game_wdata(game_wdata), .game_ack(game_ack), .game_rdata(game_rdata),
      .clear_start(clear_start), .clear_busy(clear_busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_x(mem_x), .mem_y(mem_y),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port grid memory with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) bmem[mem_y][mem_x] <= mem_wdata;
         else        mem_rdata <= bmem[mem_y][mem_x];
      end
   end

   function automatic bit inRange(input int x, input int y);
      return (x >= 1) && (x <= GW) && (y >= 1) && (y <= GH);
   endfunction

   function automatic int expClear(input int x, input int y);
`ifdef GRID_BORDER_WALL_EN
      if (x == 1 || x == GW || y == 1 || y == GH) return 3;
`endif
      return 0;
   endfunction

   function automatic int cellAt(input int x, input int y);
      return inRange(x, y) ? shadow[y][x] : 0;
   endfunction

   task automatic clearShadow();
      for (int y = 0; y <= GH + 1; y++)
         for (int x = 0; x <= GW + 1; x++)
            shadow[y][x] = inRange(x, y) ? expClear(x, y) : 0;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      vec_count++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: VGA data is due two cycles after each fetch and must hold otherwise; every ack pops one entry.
   always @(negedge clk) begin
      if (!reset) begin
         vga_due  = 2'b00;
         last_vga = 0;
      end else begin
         if (vga_due[1] && vga_q.size() > 0) begin
            last_vga = vga_q.pop_front();
            checkOutput("vga_data", int'(vga_data), last_vga);
         end else begin
            checkOutput("vga_hold", int'(vga_data), last_vga);
         end
         vga_due = {vga_due[0], vga_req};
         if (game_ack) begin
            if (game_q.size() == 0) begin
               checkOutput("game_ack_spurious", int'(game_ack), 0);
            end else begin
               game_exp_t e;
               e = game_q.pop_front();
               if (e.is_read) checkOutput("game_rdata", int'(game_rdata), e.rdata);
            end
         end
         if (mem_en) checkOutput("mem_coord_range", int'(inRange(int'(mem_x), int'(mem_y))), 1);
      end
   end

   task automatic waitAck(output int latency);
      latency = -1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (game_ack) begin
            latency = cyc - req_cyc;
            return;
         end
      end
      checkOutput("game_ack_timeout", int'(game_ack), 1);
   endtask

   // One transaction: optional VGA fetch and/or game access issued in the same cycle.
   task automatic applyStimulus(input bit do_vga, input int vx, input int vy,
                                input bit do_game, input bit we, input int gx, input int gy,
                                input int wd);
      int l;
      @(posedge clk); #1;
      if (do_vga) begin
         vga_req = 1'b1;
         vga_x   = CW'(vx);
         vga_y   = CW'(vy);
         vga_q.push_back(cellAt(vx, vy));
      end
      if (do_game) begin
         game_req   = 1'b1;
         game_we    = we;
         game_x     = CW'(gx);
         game_y     = CW'(gy);
         game_wdata = DW'(wd);
         game_q.push_back('{!we, we ? 0 : cellAt(gx, gy)});
         if (we && inRange(gx, gy)) shadow[gy][gx] = wd;
         req_cyc = cyc;
      end
      @(posedge clk); #1;
      vga_req = 1'b0;
      vga_x   = '0;
      vga_y   = '0;
      if (do_game) begin
         waitAck(l);
         checkOutput("game_latency", l, do_vga ? 2 : 1);
         @(posedge clk); #1;
         game_req = 1'b0;
         game_we  = 1'b0;
      end
      repeat (2) @(posedge clk);
   endtask

   // Follows a clear sweep cycle by cycle; optionally injects traffic or pulls reset at reset_at.
   task automatic checkSweep(input int reset_at, input bit traffic);
      logic [14:0] act_vec;
      logic [14:0] exp_vec;
      int j;
      for (int i = 0; i < SWEEP; i++) begin
         @(negedge clk);
         if (i == reset_at) begin
            checkOutput("reset_mid_sweep", int'({vga_data, game_ack, game_rdata, clear_busy, mem_en,
                                                 mem_we, mem_x, mem_y, mem_wdata}), 0);
            return;
         end
         act_vec = {clear_busy, mem_en, mem_we, mem_x, mem_y, mem_wdata};
         exp_vec = {1'b1, 1'b1, 1'b1, CW'((i % GW) + 1), CW'((i / GW) + 1),
                    DW'(expClear((i % GW) + 1, (i / GW) + 1))};
         checkOutput("sweep_write", int'(act_vec), int'(exp_vec));
         @(posedge clk); #1;
         j = i + 1;
         clear_start = traffic && (j == 50);
         vga_req     = traffic && (j == 20);
         vga_x       = (traffic && j == 20) ? CW'(3) : '0;
         vga_y       = (traffic && j == 20) ? CW'(4) : '0;
         if (traffic && j == 20) vga_q.push_back(0);
         if (traffic && j == 10) begin
            game_req = 1'b1;
            game_we  = 1'b0;
            game_x   = CW'(3);
            game_y   = CW'(4);
            game_q.push_back('{1'b1, cellAt(3, 4)});
            req_cyc  = cyc;
         end
         if (j == reset_at) reset = 1'b0;
      end
   endtask

   task automatic afterSweep();
      @(negedge clk);
      checkOutput("sweep_done_busy", int'(clear_busy), 0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_outputs", int'({vga_data, game_ack, game_rdata, clear_busy, mem_en,
                                         mem_we, mem_x, mem_y, mem_wdata}), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      checkSweep(-1, 1'b0);
      afterSweep();
      clearShadow();

      $display("[TB] directed game write/read and arbitration");
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, 3, 4, 1);
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 3, 4, 0);
      applyStimulus(1'b1, 3, 4, 1'b1, 1'b0, 5, 5, 0);
      applyStimulus(1'b1, 0, 5, 1'b1, 1'b0, 16, 2, 0);
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, 0, 9, 2);
      applyStimulus(1'b1, 16, 16, 1'b0, 1'b0, 0, 0, 0);

      $display("[TB] randomised traffic");
      for (int n = 0; n < 60; n++) begin
         int kind;
         kind = int'($urandom_range(0, 2));
         applyStimulus(kind != 1, int'($urandom_range(0, 16)), int'($urandom_range(0, 16)),
                       kind != 0, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 16)), int'($urandom_range(0, 16)),
                       int'($urandom_range(0, 3)));
      end

      $display("[TB] clear_start after a read grant");
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, 3, 4, 1);
      @(posedge clk); #1;
      game_req = 1'b1;
      game_we  = 1'b0;
      game_x   = CW'(3);
      game_y   = CW'(4);
      game_q.push_back('{1'b1, cellAt(3, 4)});
      req_cyc  = cyc;
      @(posedge clk); #1;
      clear_start = 1'b1;
      clearShadow();
      @(negedge clk);
      checkOutput("ack_across_clear", int'(game_ack), 1);
      @(posedge clk); #1;
      clear_start = 1'b0;
      game_req    = 1'b0;
      checkSweep(-1, 1'b1);
      afterSweep();
      waitAck(lat);
      checkOutput("clear_wait_latency", lat, SWEEP - 10 + 1);
      @(posedge clk); #1;
      game_req = 1'b0;
      repeat (2) @(posedge clk);

      $display("[TB] reset in the middle of a sweep");
      @(posedge clk); #1;
      clear_start = 1'b1;
      clearShadow();
      @(posedge clk); #1;
      clear_start = 1'b0;
      checkSweep(100, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      checkSweep(-1, 1'b0);
      afterSweep();

      applyStimulus(1'b1, 1, 7, 1'b0, 1'b0, 0, 0, 0);
      applyStimulus(1'b1, 8, 8, 1'b1, 1'b0, 1, 7, 0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("vga_queue_drained", vga_q.size(), 0);
      checkOutput("game_queue_drained", game_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
